// File: rtl/bit_reverse_accel_stream_tx.sv
// bit_reverse_accel_stream_tx
// Stream transmitter for the bit-reverse accelerator. Words pushed by the
// datapath are stored bit-reversed in a small FIFO and sent downstream
// with an end-of-packet flag. One packet is framed per ap_start command.
//
// Ports:
//   ap_clk, ap_rst_n            clock, async active-low reset
//   ap_start, len               start command and packet length (words)
//   ap_idle, ap_done            idle level, one-cycle completion pulse
//   src_data, src_vld, src_ack  input push interface from the datapath
//   data_out, vld_out, ack_out  output stream (valid/ack)
//   last_out                    final word of the packet
module bit_reverse_accel_stream_tx #(
    parameter int unsigned DataWidth = 32,
    parameter int unsigned LenWidth  = 16,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    input  logic                 ap_start,
    input  logic [LenWidth-1:0]  len,
    output logic                 ap_idle,
    output logic                 ap_done,
    input  logic [DataWidth-1:0] src_data,
    input  logic                 src_vld,
    output logic                 src_ack,
    output logic [DataWidth-1:0] data_out,
    output logic                 vld_out,
    input  logic                 ack_out,
    output logic                 last_out
);

    localparam int unsigned PtrWidth = $clog2(FifoDepth);
    localparam int unsigned CntWidth = PtrWidth + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [DataWidth-1:0]  r_mem_data [FifoDepth];
    logic [FifoDepth-1:0]  r_mem_last;
    logic [PtrWidth-1:0]   r_wr_ptr;
    logic [PtrWidth-1:0]   r_rd_ptr;
    logic [CntWidth-1:0]   r_count;

    logic [LenWidth-1:0]   r_len_q;
    logic [LenWidth-1:0]   r_in_cnt;
    logic [LenWidth-1:0]   r_out_cnt;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_start;
    logic                  w_last_in;
    logic                  w_last_pop;
    logic [DataWidth-1:0]  w_rev;

    // FIFO status and handshakes
    assign w_full     = (r_count == CntWidth'(FifoDepth));
    assign w_empty    = (r_count == '0);
    assign src_ack    = (r_state == ST_RUN) && (r_in_cnt < r_len_q) && !w_full;
    assign w_push     = src_vld && src_ack;
    assign vld_out    = !w_empty;
    assign w_pop      = vld_out && ack_out;
    assign data_out   = r_mem_data[r_rd_ptr];
    assign last_out   = r_mem_last[r_rd_ptr];
    assign w_start    = (r_state == ST_IDLE) && ap_start;
    assign w_last_in  = (r_in_cnt == r_len_q - LenWidth'(1));
    // Words leave in order, so the final pop is the one at index len-1
    assign w_last_pop = w_pop && (r_out_cnt == r_len_q - LenWidth'(1));

    // Mirror the input word: bit i takes bit DataWidth-1-i
    always_comb begin
        w_rev = '0;
        for (int unsigned i = 0; i < DataWidth; i++) begin
            w_rev[i] = src_data[DataWidth-1-i];
        end
    end

    // State register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (ap_start) begin
                    w_state_nxt = (len != '0) ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_last_pop) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Control outputs decoded from the registered state
    always_comb begin
        ap_idle = 1'b0;
        ap_done = 1'b0;
        unique case (r_state)
            ST_IDLE: ap_idle = 1'b1;
            ST_DONE: ap_done = 1'b1;
            default: ;
        endcase
    end

    // Packet length and word counters
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_len_q   <= '0;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else if (w_start) begin
            r_len_q   <= len;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            if (w_push) begin
                r_in_cnt <= r_in_cnt + LenWidth'(1);
            end
            if (w_pop) begin
                r_out_cnt <= r_out_cnt + LenWidth'(1);
            end
        end
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            for (int unsigned i = 0; i < FifoDepth; i++) begin
                r_mem_data[i] <= '0;
            end
            r_mem_last <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_mem_data[r_wr_ptr] <= w_rev;
                r_mem_last[r_wr_ptr] <= w_last_in;
                r_wr_ptr             <= r_wr_ptr + PtrWidth'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PtrWidth'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CntWidth'(1);
                2'b01:   r_count <= r_count - CntWidth'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_bit_reverse_accel_stream_tx.sv
// Scoreboard bench for bit_reverse_accel_stream_tx: packets are queued as
// source words plus expected output beats; monitors consume both queues.
module tb_bit_reverse_accel_stream_tx;

    logic        clk;
    logic        rst_n;
    logic        ap_start;
    logic [15:0] len;
    logic        ap_idle;
    logic        ap_done;
    logic [31:0] src_data;
    logic        src_vld;
    logic        src_ack;
    logic [31:0] data_out;
    logic        vld_out;
    logic        ack_out;
    logic        last_out;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int done_cnt = 0;
    int beat_total = 0;
    int acc_cnt = 0;
    int ack_mode = 0;      // 0: always ready, 1: random, 2: stalled
    bit vld_rand = 0;

    logic [31:0] src_words[$];
    logic [32:0] exp_q[$];
    int          beat_cycles[$];

    bit          prev_stall = 0;
    logic [32:0] prev_word = '0;
    bit          exp_done = 0;

    bit_reverse_accel_stream_tx #(
        .DataWidth(32),
        .LenWidth (16),
        .FifoDepth(4)
    ) dut (
        .ap_clk  (clk),
        .ap_rst_n(rst_n),
        .ap_start(ap_start),
        .len     (len),
        .ap_idle (ap_idle),
        .ap_done (ap_done),
        .src_data(src_data),
        .src_vld (src_vld),
        .src_ack (src_ack),
        .data_out(data_out),
        .vld_out (vld_out),
        .ack_out (ack_out),
        .last_out(last_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Reference: reverse by shifting bits out of x into r
    function automatic logic [31:0] ref_rev(input logic [31:0] x);
        logic [31:0] r = '0;
        logic [31:0] v = x;
        for (int i = 0; i < 32; i++) begin
            r = (r << 1) | (v & 32'd1);
            v = v >> 1;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Source and sink drivers
    always @(posedge clk) begin
        #1;
        if (src_words.size() > 0) begin
            src_data = src_words[0];
            src_vld  = vld_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end else begin
            src_data = $urandom;
            src_vld  = 1'b0;
        end
        case (ack_mode)
            0:       ack_out = 1'b1;
            1:       ack_out = 1'($urandom_range(0, 1));
            default: ack_out = 1'b0;
        endcase
    end

    // Input-side monitor: consume a source word on each accepted push
    always @(negedge clk) begin
        if (rst_n && src_vld && src_ack) begin
            if (src_words.size() > 0) void'(src_words.pop_front());
            acc_cnt++;
        end
    end

    // Output-side monitor: scoreboard compare, stall stability, done timing
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
            exp_done   = 0;
        end else begin
            if (exp_done) begin
                chk("done_after_last", 64'(ap_done), 64'd1);
                exp_done = 0;
            end
            if (prev_stall) begin
                chk("stall_vld_held", 64'(vld_out), 64'd1);
                chk("stall_word_held", 64'({last_out, data_out}), 64'(prev_word));
            end
            if (ap_done) done_cnt++;
            if (vld_out && ack_out) begin
                beat_cycles.push_back(cyc);
                beat_total++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected none", {last_out, data_out});
                end else begin
                    chk("beat", 64'({last_out, data_out}), 64'(exp_q.pop_front()));
                end
                if (last_out) exp_done = 1;
            end
            prev_stall = vld_out && !ack_out;
            prev_word  = {last_out, data_out};
        end
    end

    task automatic load_pkt(input int n, input bit inc);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = inc ? 32'(i + 1) : $urandom;
            src_words.push_back(w);
            exp_q.push_back({(i == n - 1), ref_rev(w)});
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        @(posedge clk); #1;
        while (!ap_idle && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("idle_reached", 64'(ap_idle), 64'd1);
    endtask

    task automatic start_pkt(input int n);
        ap_start = 1'b1;
        len      = 16'(n);
        @(posedge clk); #1;
        ap_start = 1'b0;
    endtask

    task automatic wait_pkt_end(input int done_before, input int budget);
        int k = 0;
        while (done_cnt == done_before && k < budget) begin
            @(negedge clk); #1;
            k++;
        end
        chk("pkt_done_seen", 64'(done_cnt != done_before), 64'd1);
        chk("pkt_drained", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("single_done", 64'(done_cnt - done_before), 64'd1);
    endtask

    task automatic run_pkt(input int n, input bit inc);
        int db;
        int bb;
        wait_idle();
        db = done_cnt;
        bb = beat_total;
        load_pkt(n, inc);
        start_pkt(n);
        wait_pkt_end(db, 600);
        chk("pkt_beats", 64'(beat_total - bb), 64'(n));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int db;
        int bb;
        int ab;

        rst_n    = 1'b0;
        ap_start = 1'b0;
        len      = '0;
        src_data = '0;
        src_vld  = 1'b0;
        ack_out  = 1'b0;

        // Reset values before any clock edge
        #2;
        chk("rst_idle", 64'(ap_idle), 64'd1);
        chk("rst_done", 64'(ap_done), 64'd0);
        chk("rst_src_ack", 64'(src_ack), 64'd0);
        chk("rst_vld", 64'(vld_out), 64'd0);
        chk("rst_last", 64'(last_out), 64'd0);
        chk("rst_data", 64'(data_out), 64'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // len=1, data 1: latency, done and idle timing
        wait_idle();
        db = done_cnt;
        load_pkt(1, 1'b1);
        start_pkt(1);
        @(negedge clk);
        chk("t1_in_hs", 64'(src_vld && src_ack), 64'd1);
        @(negedge clk);
        chk("t1_vld", 64'(vld_out), 64'd1);
        chk("t1_data", 64'(data_out), 64'h8000_0000);
        chk("t1_last", 64'(last_out), 64'd1);
        @(negedge clk);
        chk("t1_done", 64'(ap_done), 64'd1);
        @(negedge clk);
        chk("t1_idle", 64'(ap_idle), 64'd1);
        chk("t1_done_low", 64'(ap_done), 64'd0);
        chk("t1_done_count", 64'(done_cnt - db), 64'd1);

        // len=8 streaming: 8 back-to-back beats
        beat_cycles.delete();
        run_pkt(8, 1'b1);
        chk("t2_beats", 64'(beat_cycles.size()), 64'd8);
        if (beat_cycles.size() == 8)
            chk("t2_consecutive", 64'(beat_cycles[7] - beat_cycles[0]), 64'd7);

        // len=10 with output stalled: FIFO fills at 4 words
        wait_idle();
        ack_mode = 2;
        db = done_cnt;
        ab = acc_cnt;
        load_pkt(10, 1'b1);
        start_pkt(10);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("t3_accepted", 64'(acc_cnt - ab), 64'd4);
        chk("t3_src_ack_low", 64'(src_ack), 64'd0);
        chk("t3_vld_held", 64'(vld_out), 64'd1);
        chk("t3_head", 64'(data_out), 64'(ref_rev(32'd1)));
        ack_mode = 0;
        wait_pkt_end(db, 200);

        // len=0: done next cycle, idle after, no beats
        wait_idle();
        db = done_cnt;
        bb = beat_total;
        start_pkt(0);
        @(negedge clk);
        chk("t4_done", 64'(ap_done), 64'd1);
        chk("t4_no_vld", 64'(vld_out), 64'd0);
        @(negedge clk);
        chk("t4_idle", 64'(ap_idle), 64'd1);
        chk("t4_done_low", 64'(ap_done), 64'd0);
        chk("t4_no_beats", 64'(beat_total - bb), 64'd0);

        // ap_start during RUN is ignored
        wait_idle();
        db = done_cnt;
        bb = beat_total;
        load_pkt(3, 1'b0);
        start_pkt(3);
        ap_start = 1'b1;
        len      = 16'd5;
        repeat (2) begin
            @(posedge clk); #1;
        end
        ap_start = 1'b0;
        wait_pkt_end(db, 100);
        chk("t5_beats", 64'(beat_total - bb), 64'd3);

        // Reset with two words held in the FIFO
        wait_idle();
        ack_mode = 2;
        load_pkt(6, 1'b0);
        start_pkt(6);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("t6_pre_vld", 64'(vld_out), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", 64'(vld_out), 64'd0);
        chk("t6_rst_src_ack", 64'(src_ack), 64'd0);
        chk("t6_rst_idle", 64'(ap_idle), 64'd1);
        chk("t6_rst_data", 64'(data_out), 64'd0);
        src_words.delete();
        exp_q.delete();
        ack_mode = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        db = done_cnt;
        repeat (4) @(negedge clk);
        #1;
        chk("t6_no_done", 64'(done_cnt - db), 64'd0);
        chk("t6_idle_after", 64'(ap_idle), 64'd1);
        run_pkt(2, 1'b0);

        // Randomized packets with random source and sink pacing
        vld_rand = 1;
        ack_mode = 1;
        for (int p = 0; p < 25; p++) begin
            run_pkt($urandom_range(1, 12), 1'b0);
        end
        vld_rand = 0;
        ack_mode = 0;

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bit_reverse_accel_stream_tx.md
# bit_reverse_accel_stream_tx

Stream transmitter for the bit-reverse accelerator. It accepts words from the accelerator datapath on a valid/ack push interface and stores them bit-reversed in a small FIFO. It then drives them out on a valid/ack stream with an end-of-packet flag, feeding the register-slice/stream fabric downstream. A start/done control handshake frames one packet per command, so it acts as the producing end for the stream slices.

## Interface
- DataWidth, 32, stream word width
- LenWidth, 16, width of packet length field (words)
- FifoDepth, 4, internal FIFO entries; power of two, ≥2
- ap_clk  in  1  clock, all logic on rising edge
- ap_rst_n  in  1  reset, asynchronous, active-low
- ap_start  in  1  start command, sampled only in IDLE
- len  in  LenWidth  packet length in words, latched when ap_start is accepted
- ap_idle  out  1  high while in IDLE
- ap_done  out  1  one-cycle pulse at packet completion
- src_data  in  DataWidth  word from accelerator datapath
- src_vld  in  1  src_data valid
- src_ack  out  1  transmitter can take src_data this cycle
- data_out  out  DataWidth  bit-reversed stream word
- vld_out  out  1  data_out/last_out valid
- ack_out  in  1  downstream accepts data_out
- last_out  out  1  marks final word of packet

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE → RUN: on ap_start=1 with len≠0. Latch len, clear in_cnt and out_cnt.
- IDLE → DONE: on ap_start=1 with len=0. No transfers occur.
- RUN → DONE: on the output handshake (vld_out & ack_out) of the word with last_out=1.
- DONE → IDLE: unconditionally after one cycle. ap_done=1 only in DONE.
- ap_start is ignored in RUN and DONE.
- src_ack = (state==RUN) & (in_cnt<len_q) & ~fifo_full. It depends on registered state only; there is no combinational path from ack_out.
- Input handshake is src_vld & src_ack. On it, push {bit_reverse(src_data), in_cnt==len_q-1} and increment in_cnt.
- bit_reverse: output bit i = input bit DataWidth-1-i.
- vld_out = fifo not empty. data_out/last_out = FIFO head.
- Output handshake is vld_out & ack_out. On it, pop the FIFO and increment out_cnt.
- FIFO simultaneous push and pop:
  - When full: push is blocked because src_ack=0; the pop proceeds.
  - When empty: nothing is popped because vld_out=0; the push proceeds.
  - Otherwise: count is unchanged and both pointers advance.
- Pointers wrap modulo FifoDepth. A count register of width log2(FifoDepth)+1 distinguishes full from empty.
- Counters are LenWidth bits. len=2^LenWidth-1 must complete without overflow.

## Timing
- Reset (ap_rst_n=0) takes effect asynchronously with no clock. Values while in reset:
  - state=IDLE, ap_idle=1, ap_done=0
  - src_ack=0, vld_out=0, last_out=0, data_out=0
  - FIFO storage, pointers and counters cleared
- Reset mid-packet: vld_out drops immediately and FIFO contents are discarded. After release the block is in IDLE and no ap_done is issued for the aborted packet.
- ap_start sampled in IDLE at edge N: state=RUN and src_ack can be 1 in cycle N+1.
- Latency: a word accepted at edge N appears on data_out with vld_out=1 in cycle N+1, provided the FIFO was empty.
- Throughput: one word per cycle sustained while ack_out=1.
- Stability: while vld_out=1 and ack_out=0, data_out and last_out hold stable. vld_out never drops without a handshake, except on reset.
- ap_done pulses in the cycle after the last output handshake. ap_idle returns one cycle later, and a new ap_start is accepted there.
- With len=0: ap_done in the cycle after start, then IDLE.

## Test plan
- Reset, then len=1 and src_data=32'h0000_0001. Require:
  - data_out=32'h8000_0000 with last_out=1 one cycle after the input handshake.
  - ap_done one cycle after the output handshake.
  - ap_idle one cycle after ap_done.
- len=8, src_vld=1 and ack_out=1 continuously, data 32'h1..32'h8. Require:
  - 8 consecutive output beats in order.
  - last_out only on the beat carrying bit_reverse(32'h8)=32'h1000_0000.
  - Exactly one ap_done.
- len=10, ack_out=0 for 6 cycles then 1. Require:
  - src_ack falls after exactly 4 accepted words (FIFO full).
  - data_out stays constant while stalled.
  - All 10 words delivered in order.
- len=0 start. Require no vld_out, ap_done at start+1 and ap_idle at start+2. Assert ap_start again during RUN of a len=3 packet: require it is ignored, with exactly 3 beats and one ap_done.
- Assert ap_rst_n low mid-packet with 2 words in the FIFO. Require vld_out=0 and src_ack=0 immediately, with no clock edge. After release, a fresh len=2 packet completes with correct data and last_out.
